pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_md_busy_tracker.sv | 73 +++++++
 rtl/pipe_hazard_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its mul/div tracker.
package pipe_pkg;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Tracks an in-flight multi-cycle mul/div: busy for MD_LAT-1 cycles after issue,
// then a one-cycle done pulse, with back-to-back reissue allowed from DONE.
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mdStartE,
  output logic mdBusy,
  output logic mdDone
);

  localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 1);

  md_state_t  state;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (mdStartE) begin
            state  <= MD_BUSY;
            cnt    <= CNT_LOAD;
            mdBusy <= 1'b1;
            mdDone <= 1'b0;
          end
        end
        // A start while busy is a protocol error and is deliberately ignored here.
        MD_BUSY: begin
          if (cnt == 4'd1) begin
            state  <= MD_DONE;
            cnt    <= '0;
            mdBusy <= 1'b0;
            mdDone <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        MD_DONE: begin
          if (mdStartE) begin
            state  <= MD_BUSY;
            cnt    <= CNT_LOAD;
            mdBusy <= 1'b1;
          end else begin
            state  <= MD_IDLE;
            mdBusy <= 1'b0;
          end
          mdDone <= 1'b0;
        end
        default: begin
          state  <= MD_IDLE;
          cnt    <= '0;
          mdBusy <= 1'b0;
          mdDone <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset && state == MD_BUSY)
      assert (!mdStartE) else $error("md_busy_tracker: mdStartE issued while unit busy");
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use / branch /
// mul-div stalls, redirect flushes and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic              pcSrcD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              mdOpD,
  input  logic              mdStartE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mdBusy,
  output logic              mdDone,
  output logic [CNT_W-1:0]  stallCnt
);

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic regHit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (RegWriteM && regHit(WriteRegM, src))
      return FWD_MEM;
    else if (RegWriteW && regHit(WriteRegW, src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  logic lwStall, brStall, mdStall, anyStall;

  md_busy_tracker #(.MD_LAT(MD_LAT)) uMdBusy (
    .clk      (clk),
    .reset    (reset),
    .mdStartE (mdStartE),
    .mdBusy   (mdBusy),
    .mdDone   (mdDone)
  );

  always_comb begin
    ForwardAE = fwdSel(RsE);
    ForwardBE = fwdSel(RtE);
    ForwardAD = RegWriteM && regHit(WriteRegM, RsD);
    ForwardBD = RegWriteM && regHit(WriteRegM, RtD);

    lwStall  = MemtoRegE && (regHit(RtE, RsD) || regHit(RtE, RtD));
    brStall  = branchD &&
               ((RegWriteE && (regHit(WriteRegE, RsD) || regHit(WriteRegE, RtD))) ||
                (MemtoRegM && (regHit(WriteRegM, RsD) || regHit(WriteRegM, RtD))));
    mdStall  = mdOpD && (mdBusy || mdStartE);
    anyStall = lwStall || brStall || mdStall;

    stallF = anyStall;
    stallD = anyStall;
    flushE = anyStall;
    // A redirect waits until the stalled D instruction is allowed to move.
    flushD = (pcSrcD || jumpD) && !anyStall;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stallCnt <= '0;
    else if (stallD && (stallCnt != '1))
      stallCnt <= stallCnt + CNT_W'(1);
  end

endmodule
